// File: rtl/mem_port_arb_pkg.sv
// Shared definitions for the memory-port arbiter: memory bus widths,
// the single-beat burst constant and a ceil-log2 helper for id/count widths.
package mem_port_arb_pkg;

  localparam int          MEM_ADDR_W  = 32;
  localparam int          MEM_DATA_W  = 32;
  localparam logic [31:0] MEM_BURST_1 = 32'd1;

  // Smallest width able to index 'value' entries (never below 1).
  function automatic int log2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/mem_port_arb_tag_fifo.sv
// In-order FIFO of client ids for reads in flight. Pointers are
// power-of-two sized so they wrap naturally; count is the registered fill.
module arb_tag_fifo
  import mem_port_arb_pkg::*;
#(
  parameter  int WIDTH = 2,
  parameter  int DEPTH = 16,
  localparam int PTR_W = log2(DEPTH),
  localparam int CNT_W = log2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (count_r == {CNT_W{1'b0}});
  assign full      = (count_r == CNT_W'(DEPTH));
  assign count     = count_r;
  assign dout      = mem_r[rd_ptr_r];
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  // Storage write; no reset needed since entries are only read when counted.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; push+pop leaves the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arb.sv
// Round-robin arbiter sharing one single-beat memory port among several
// memory controllers. Reads are tagged in order so responses return to
// the client that issued them; writes bypass the tag FIFO entirely.
module mem_port_arb
  import mem_port_arb_pkg::*;
#(
  parameter  int NUM_CLIENTS = 4,
  parameter  int ADDR_WIDTH  = MEM_ADDR_W,
  parameter  int DATA_WIDTH  = MEM_DATA_W,
  parameter  int TAG_DEPTH   = 16,
  localparam int CID_W       = log2(NUM_CLIENTS),
  localparam int CNT_W       = log2(TAG_DEPTH + 1)
) (
  input  logic                              aclk,
  input  logic                              arst,
  input  logic [NUM_CLIENTS-1:0]            cl_req_din,
  output logic [NUM_CLIENTS-1:0]            cl_req_full_n,
  input  logic [NUM_CLIENTS-1:0]            cl_req_write,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] cl_address,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] cl_dataout,
  input  logic [NUM_CLIENTS*32-1:0]         cl_size,
  output logic [NUM_CLIENTS-1:0]            cl_rsp_empty_n,
  input  logic [NUM_CLIENTS-1:0]            cl_rsp_read,
  output logic [DATA_WIDTH-1:0]             cl_datain,
  output logic                              mem_req_din,
  input  logic                              mem_req_full_n,
  output logic                              mem_req_write,
  output logic [ADDR_WIDTH-1:0]             mem_address,
  output logic [DATA_WIDTH-1:0]             mem_dataout,
  output logic [31:0]                       mem_size,
  input  logic                              mem_rsp_empty_n,
  output logic                              mem_rsp_read,
  input  logic [DATA_WIDTH-1:0]             mem_datain,
  output logic [CNT_W-1:0]                  outstanding
);

  logic [CID_W-1:0]       rr_ptr_r;
  logic [NUM_CLIENTS-1:0] eligible_s;
  logic [CID_W-1:0]       gnt_s;
  logic                   any_elig_s;
  logic                   accept_s;
  logic                   push_s;
  logic [CID_W-1:0]       head_s;
  logic                   tag_empty_s;
  logic                   tag_full_s;

  // tag_full comes from the registered count, keeping cl_rsp_read off the request path.
  assign eligible_s = cl_req_din & (cl_req_write | {NUM_CLIENTS{~tag_full_s}});
  assign accept_s   = mem_req_din & mem_req_full_n;
  assign push_s     = accept_s & ~mem_req_write;
  assign cl_datain  = mem_datain;

  // Round-robin search: first eligible client at or above rr_ptr, wrapping.
  always_comb begin
    int cand;
    gnt_s      = rr_ptr_r;
    any_elig_s = 1'b0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      cand = int'(rr_ptr_r) + k;
      if (cand >= NUM_CLIENTS) begin
        cand = cand - NUM_CLIENTS;
      end else begin
        cand = cand;
      end
      if (!any_elig_s && eligible_s[cand]) begin
        gnt_s      = cand[CID_W-1:0];
        any_elig_s = 1'b1;
      end else begin
        any_elig_s = any_elig_s;
      end
    end
  end

  // Request mux toward memory and the per-client accept strobe.
  always_comb begin
    int gi;
    gi            = int'(gnt_s);
    cl_req_full_n = {NUM_CLIENTS{1'b0}};
    if (any_elig_s && !arst) begin
      mem_req_din       = 1'b1;
      mem_req_write     = cl_req_write[gi];
      mem_address       = cl_address[gi*ADDR_WIDTH +: ADDR_WIDTH];
      mem_dataout       = cl_dataout[gi*DATA_WIDTH +: DATA_WIDTH];
      mem_size          = cl_size[gi*32 +: 32];
      cl_req_full_n[gi] = mem_req_full_n;
    end else begin
      mem_req_din   = 1'b0;
      mem_req_write = 1'b0;
      mem_address   = {ADDR_WIDTH{1'b0}};
      mem_dataout   = {DATA_WIDTH{1'b0}};
      mem_size      = 32'd0;
    end
  end

  // Response steering to the client at the head of the tag FIFO.
  always_comb begin
    cl_rsp_empty_n = {NUM_CLIENTS{1'b0}};
    if (!tag_empty_s && !arst) begin
      cl_rsp_empty_n[head_s] = mem_rsp_empty_n;
      mem_rsp_read           = cl_rsp_read[head_s] & mem_rsp_empty_n;
    end else begin
      mem_rsp_read = 1'b0;
    end
  end

  // Advance the round-robin pointer past the client just accepted.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      rr_ptr_r <= {CID_W{1'b0}};
    end else if (accept_s) begin
      if (gnt_s == CID_W'(NUM_CLIENTS - 1)) begin
        rr_ptr_r <= {CID_W{1'b0}};
      end else begin
        rr_ptr_r <= gnt_s + 1'b1;
      end
    end
  end

  arb_tag_fifo #(
    .WIDTH (CID_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk   (aclk),
    .rst   (arst),
    .push  (push_s),
    .pop   (mem_rsp_read),
    .din   (gnt_s),
    .dout  (head_s),
    .empty (tag_empty_s),
    .full  (tag_full_s),
    .count (outstanding)
  );

endmodule
